// File: rtl/ravenna_flash_dac_player.sv
// Boot-time sample player: wakes the SPI flash, streams 16-bit words by continuous read
// (cmd 0x03) and drives the 10-bit DAC code until an erased word (0xFFFF) is found.
module ravenna_flash_dac_player #(
    parameter logic [23:0] BASE_ADDR  = 24'h010000,
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned WAKE_WAIT  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       flash_csb,
    output logic       flash_clk,
    output logic       flash_io0,
    input  logic       flash_io1,
    output logic       flash_io2,
    output logic       flash_io3,
    output logic [9:0] dac_value,
    output logic       dac_ena,
    output logic       done
);

    typedef enum logic [2:0] {
        StWake,
        StWait,
        StCmd,
        StFetch,
        StApply,
        StHold,
        StStop
    } state_t;

    localparam int unsigned     CntW     = 16;
    localparam logic [CntW-1:0] WaitLast = CntW'(WAKE_WAIT - 1);
    localparam logic [CntW-1:0] DivLast  = CntW'(SAMPLE_DIV - 1);
    localparam logic [7:0]      WakeCmd  = 8'hAB;
    localparam logic [31:0]     ReadCmd  = {8'h03, BASE_ADDR};

    state_t          state;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] period_cnt;
    logic [31:0]     tx_sr;
    logic [15:0]     rx_sr;
    logic [5:0]      bits_left;
    logic            shifting;
    logic            last_bit;

    assign flash_io2 = 1'b1;
    assign flash_io3 = 1'b1;

    // The bit engine runs only while a state is actually moving bits on the bus.
    assign shifting = ((state == StWake) && (cnt == 16'd2)) ||
                      ((state == StCmd) && (cnt == 16'd1)) ||
                      (state == StFetch);
    assign last_bit = flash_clk && (bits_left == 6'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StWake;
            cnt        <= '0;
            period_cnt <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bits_left  <= '0;
            flash_csb  <= 1'b1;
            flash_clk  <= 1'b0;
            flash_io0  <= 1'b0;
            dac_value  <= '0;
            dac_ena    <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Phase A -> phase B; at the end of phase B sample MISO and present the next bit.
            if (shifting) begin
                if (!flash_clk) begin
                    flash_clk <= 1'b1;
                end else begin
                    flash_clk <= 1'b0;
                    rx_sr     <= {rx_sr[14:0], flash_io1};
                    bits_left <= bits_left - 6'd1;
                    if (bits_left != 6'd1) begin
                        flash_io0 <= tx_sr[31];
                        tx_sr     <= {tx_sr[30:0], 1'b0};
                    end
                end
            end

            case (state)
                StWake: begin
                    if (cnt == 16'd0) begin
                        flash_csb <= 1'b0;
                        cnt       <= 16'd1;
                    end else if (cnt == 16'd1) begin
                        flash_io0 <= WakeCmd[7];
                        tx_sr     <= {WakeCmd[6:0], 25'd0};
                        bits_left <= 6'd8;
                        cnt       <= 16'd2;
                    end else if (cnt == 16'd2) begin
                        if (last_bit) begin
                            cnt <= 16'd3;
                        end
                    end else begin
                        flash_csb <= 1'b1;
                        cnt       <= '0;
                        state     <= StWait;
                    end
                end

                StWait: begin
                    if (cnt == WaitLast) begin
                        flash_csb <= 1'b0;
                        cnt       <= '0;
                        state     <= StCmd;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                StCmd: begin
                    if (cnt == 16'd0) begin
                        flash_io0 <= ReadCmd[31];
                        tx_sr     <= {ReadCmd[30:0], 1'b0};
                        bits_left <= 6'd32;
                        cnt       <= 16'd1;
                    end else if (last_bit) begin
                        // Data bits follow the address with no gap; the period starts here.
                        flash_io0  <= 1'b0;
                        bits_left  <= 6'd16;
                        period_cnt <= '0;
                        cnt        <= '0;
                        state      <= StFetch;
                    end
                end

                StFetch: begin
                    period_cnt <= period_cnt + 16'd1;
                    if (last_bit) begin
                        state <= StApply;
                    end
                end

                StApply: begin
                    period_cnt <= period_cnt + 16'd1;
                    if (rx_sr == 16'hFFFF) begin
                        flash_csb <= 1'b1;
                        done      <= 1'b1;
                        state     <= StStop;
                    end else begin
                        dac_value <= rx_sr[9:0];
                        dac_ena   <= rx_sr[15];
                        state     <= StHold;
                    end
                end

                StHold: begin
                    if (period_cnt == DivLast) begin
                        period_cnt <= '0;
                        bits_left  <= 6'd16;
                        state      <= StFetch;
                    end else begin
                        period_cnt <= period_cnt + 16'd1;
                    end
                end

                StStop: begin
                    flash_csb <= 1'b1;
                end

                default: begin
                    state <= StStop;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ravenna_flash_dac_player.sv
// Bench for ravenna_flash_dac_player: behavioural SPI flash with a word table, directed
// scenarios plus random words checked against the word-format rules.
module tb_ravenna_flash_dac_player;

    localparam logic [23:0] BASE    = 24'h010000;
    localparam int unsigned DIV     = 1000;
    localparam int unsigned WW      = 16;
    localparam int unsigned CLK_T   = 10;
    localparam int unsigned BUDGET  = 2500;

    logic       clk;
    logic       resetn;
    logic       flash_csb;
    logic       flash_clk;
    logic       flash_io0;
    logic       flash_io1 = 1'b0;
    logic       flash_io2;
    logic       flash_io3;
    logic [9:0] dac_value;
    logic       dac_ena;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [15:0] words[$];

    int unsigned rise_cnt   = 0;
    logic [31:0] cmd_sr     = '0;
    logic [7:0]  first_byte = '0;
    time         io0_t      = 0;
    int unsigned mode0_viol = 0;
    int unsigned pin_viol   = 0;
    int unsigned mk;
    logic [7:0]  mb;

    int unsigned xfer_rises[$];
    logic [7:0]  xfer_first[$];
    time         csb_rise_t[$];
    time         csb_fall_t[$];
    int unsigned base_rise;
    int unsigned base_fall;

    ravenna_flash_dac_player #(
        .BASE_ADDR (BASE),
        .SAMPLE_DIV(DIV),
        .WAKE_WAIT (WW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .flash_csb(flash_csb),
        .flash_clk(flash_clk),
        .flash_io0(flash_io0),
        .flash_io1(flash_io1),
        .flash_io2(flash_io2),
        .flash_io3(flash_io3),
        .dac_value(dac_value),
        .dac_ena  (dac_ena),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        int unsigned off;
        if (a < BASE) return 8'hFF;
        off = a - BASE;
        if (off / 2 >= words.size()) return 8'hFF;
        return off[0] ? words[off/2][7:0] : words[off/2][15:8];
    endfunction

    // Flash side: count rises per CSB-low transaction, shift in command/address bits.
    always @(posedge flash_clk or negedge flash_csb) begin
        if (flash_clk) begin
            if (!flash_csb) begin
                if (($time - io0_t) < CLK_T) mode0_viol++;
                if (rise_cnt < 32) cmd_sr = {cmd_sr[30:0], flash_io0};
                rise_cnt++;
                if (rise_cnt == 8) first_byte = cmd_sr[7:0];
            end
        end else begin
            rise_cnt = 0;
            csb_fall_t.push_back($time);
        end
    end

    always @(posedge flash_csb) begin
        xfer_rises.push_back(rise_cnt);
        xfer_first.push_back(first_byte);
        csb_rise_t.push_back($time);
    end

    // Mode 0 read data: next bit shifted out after each falling flash_clk.
    always @(negedge flash_clk) begin
        #1;
        if (!flash_csb && rise_cnt >= 32 && cmd_sr[31:24] == 8'h03) begin
            mk = rise_cnt - 32;
            mb = flash_byte(cmd_sr[23:0] + 24'(mk / 8));
            flash_io1 = mb[7 - (mk % 8)];
        end
    end

    always @(flash_io0) io0_t = $time;

    always @(negedge clk) begin
        if (flash_io2 !== 1'b1 || flash_io3 !== 1'b1) pin_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s timeout", tag);
    endtask

    task automatic wait_rise(input int unsigned target, input string tag);
        int unsigned n;
        n = 0;
        while (!(!flash_csb && rise_cnt == target) && n < BUDGET) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= BUDGET) timeout_fail(tag);
    endtask

    task automatic start_run();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_csb", flash_csb, 1);
        chk("rst_fclk", flash_clk, 0);
        chk("rst_io0", flash_io0, 0);
        chk("rst_io2", flash_io2, 1);
        chk("rst_io3", flash_io3, 1);
        chk("rst_dac", dac_value, 0);
        chk("rst_ena", dac_ena, 0);
        chk("rst_done", done, 0);
        base_rise = csb_rise_t.size();
        base_fall = csb_fall_t.size();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_wake();
        int unsigned n;
        n = 0;
        while (csb_rise_t.size() <= base_rise && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (csb_rise_t.size() > base_rise) begin
            chk("wake_rises", xfer_rises[base_rise], 8);
            chk("wake_byte", xfer_first[base_rise], 8'hAB);
        end else begin
            timeout_fail("wake_xfer");
        end
    endtask

    task automatic check_cmd();
        wait_rise(32, "cmd_rise");
        chk("cmd_addr", cmd_sr, {8'h03, BASE});
        if (csb_fall_t.size() > base_fall + 1 && csb_rise_t.size() > base_rise)
            chk("csb_high_len", 32'(csb_fall_t[base_fall+1] - csb_rise_t[base_rise]), WW * CLK_T);
        else
            timeout_fail("csb_edges");
    endtask

    task automatic play();
        logic [9:0]  pv;
        logic        pe;
        logic [15:0] w;
        time         t_prev;
        time         t_now;
        pv     = '0;
        pe     = 1'b0;
        t_prev = 0;
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            wait_rise(32 + 16 * (i + 1), "word_rise");
            t_now = $time;
            if (i > 0) chk("period", 32'(t_now - t_prev), DIV * CLK_T);
            t_prev = t_now;
            @(posedge clk);
            #1;
            chk("latency_hold", {dac_ena, dac_value}, {pe, pv});
            @(posedge clk);
            #1;
            if (w == 16'hFFFF) begin
                chk("stop_keep", {dac_ena, dac_value}, {pe, pv});
                chk("stop_done", done, 1);
                chk("stop_csb", flash_csb, 1);
                chk("stop_fclk", flash_clk, 0);
                break;
            end
            pv = 10'(w % 1024);
            pe = (w >= 16'h8000);
            chk("sample", {dac_ena, dac_value}, {pe, pv});
            chk("done_low", done, 0);
        end
        repeat (40) @(posedge clk);
        #1;
        chk("frozen_csb", flash_csb, 1);
        chk("frozen_fclk", flash_clk, 0);
        chk("frozen_done", done, 1);
        chk("frozen_dac", {dac_ena, dac_value}, {pe, pv});
    endtask

    initial begin
        resetn = 1'b0;

        // Directed head of table followed by random words.
        words = {16'h83FF, 16'h8200};
        for (int i = 0; i < 5; i++) words.push_back(16'($urandom_range(0, 65534)));
        words.push_back(16'hFFFF);
        start_run();
        check_wake();
        check_cmd();
        play();

        // ena=0 word, then erased word after 0x8001.
        words = {16'h0155, 16'h8001, 16'hFFFF};
        start_run();
        check_wake();
        check_cmd();
        play();

        // Reset pulsed during the second fetch.
        words = {16'h83FF, 16'h8200, 16'hFFFF};
        start_run();
        check_wake();
        wait_rise(48, "c_first");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("c_first_val", {dac_ena, dac_value}, {1'b1, 10'd1023});
        wait_rise(56, "c_mid_fetch");
        #3;
        resetn = 1'b0;
        #1;
        chk("async_csb", flash_csb, 1);
        chk("async_dac", dac_value, 0);
        chk("async_ena", dac_ena, 0);
        chk("async_fclk", flash_clk, 0);
        start_run();
        check_wake();
        check_cmd();

        chk("mode0_io0_stable", mode0_viol, 0);
        chk("io2_io3_high", pin_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
